// File: rtl/riscv_zero_fetch.sv
// riscv_zero_fetch: single-outstanding instruction fetch unit.
// Issues one word read at a time, presents the returned word to decode
// through registered outputs, parks one response in a skid buffer while
// decode stalls, and flushes or drops in-flight work on a redirect.
module riscv_zero_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] pc_out
);

    typedef enum logic [1:0] {
        ST_REQ,   // request on the bus, waiting for acceptance
        ST_WAIT,  // request accepted, waiting for its response
        ST_DROP,  // stale request in flight, its response is thrown away
        ST_HOLD   // response parked in the skid buffer behind a stalled word
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] skid_data_q, skid_data_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_data_q, inst_data_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        slot_free;

    // Decode can take a new word this cycle if nothing is shown or it is being consumed.
    assign slot_free = !inst_valid_q || !stall;

    // Request is a pure decode of the state, masked so nothing is issued while reset is held.
    assign imem_req  = (state_q == ST_REQ) && !reset;
    assign imem_addr = fetch_pc_q & 32'hFFFF_FFFC;

    assign inst_valid = inst_valid_q;
    assign inst_data  = inst_data_q;
    assign pc_out     = pc_out_q;

    // Next-state logic: redirect overrides normal response and stall handling.
    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block can infer a latch.
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        skid_data_d  = skid_data_q;
        skid_pc_d    = skid_pc_q;
        inst_valid_d = inst_valid_q;
        inst_data_d  = inst_data_q;
        pc_out_d     = pc_out_q;

        if (redirect_en) begin
            inst_valid_d = 1'b0;
            inst_data_d  = NOP_INST;
            skid_data_d  = 32'h0;
            skid_pc_d    = 32'h0;
            fetch_pc_d   = redirect_pc & 32'hFFFF_FFFC;
            case (state_q)
                ST_REQ:  state_d = imem_ready  ? ST_DROP : ST_REQ;
                ST_WAIT: state_d = imem_rvalid ? ST_REQ  : ST_DROP;
                ST_HOLD: state_d = ST_REQ;
                ST_DROP: state_d = ST_DROP;
                default: state_d = ST_REQ;
            endcase
        end else begin
            // A consumed word leaves the slot empty unless a new one loads below.
            if (inst_valid_q && !stall) begin
                inst_valid_d = 1'b0;
                inst_data_d  = NOP_INST;
            end
            case (state_q)
                ST_REQ: begin
                    if (imem_ready) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        if (slot_free) begin
                            inst_valid_d = 1'b1;
                            inst_data_d  = imem_rdata;
                            pc_out_d     = fetch_pc_q;
                            state_d      = ST_REQ;
                        end else begin
                            skid_data_d = imem_rdata;
                            skid_pc_d   = fetch_pc_q;
                            state_d     = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        inst_valid_d = 1'b1;
                        inst_data_d  = skid_data_q;
                        pc_out_d     = skid_pc_q;
                        state_d      = ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (imem_rvalid) state_d = ST_REQ;
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q      <= ST_REQ;
            fetch_pc_q   <= RESET_PC & 32'hFFFF_FFFC;
            skid_data_q  <= 32'h0;
            skid_pc_q    <= 32'h0;
            inst_valid_q <= 1'b0;
            inst_data_q  <= NOP_INST;
            pc_out_q     <= 32'h0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            skid_data_q  <= skid_data_d;
            skid_pc_q    <= skid_pc_d;
            inst_valid_q <= inst_valid_d;
            inst_data_q  <= inst_data_d;
            pc_out_q     <= pc_out_d;
        end
    end

endmodule

// File: tb/tb_riscv_zero_fetch.sv
// Testbench for riscv_zero_fetch: directed scenarios followed by a randomized
// run, all checked against a program-order instruction stream model.
module tb_riscv_zero_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] pc_out;

    always #5 clk = ~clk;

    riscv_zero_fetch #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_data   (inst_data),
        .pc_out      (pc_out)
    );

    int checks = 0;
    int errors = 0;

    // Memory model: one pending request, fixed contents derived from the address.
    bit          mem_pending = 1'b0;
    logic [31:0] mem_addr    = 32'h0;
    int          mem_cnt     = 0;
    int          ready_pct   = 100;
    int          lat_min     = 1;
    int          lat_max     = 1;

    // Stream model: the next instruction decode must see, in program order.
    logic [31:0] exp_pc    = RESET_PC;
    int          consumed  = 0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_data = 32'h0;
    logic [31:0] prev_pc   = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock of traffic: memory responds, stimulus applied, outputs checked, then the edge.
    task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
        logic was_pending;
        logic rv;
        was_pending = mem_pending;
        rv          = 1'b0;
        imem_rdata  = $urandom;
        if (mem_pending) begin
            if (mem_cnt == 0) begin
                rv          = 1'b1;
                imem_rdata  = mem_word(mem_addr);
                mem_pending = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        imem_rvalid = rv;
        imem_ready  = ($urandom_range(99) < ready_pct);
        if (imem_req && imem_ready) begin
            mem_pending = 1'b1;
            mem_addr    = imem_addr;
            mem_cnt     = int'($urandom_range(lat_max, lat_min)) - 1;
        end
        stall       = st;
        redirect_en = rd;
        redirect_pc = rpc;

        if (imem_req) begin
            check("addr_align", 32'(imem_addr[1:0]), 32'h0);
            check("one_outstanding", 32'(was_pending), 32'h0);
        end
        if (!inst_valid) check("nop_when_idle", inst_data, NOP);
        if (prev_hold) begin
            check("hold_valid", 32'(inst_valid), 32'h1);
            check("hold_data", inst_data, prev_data);
            check("hold_pc", pc_out, prev_pc);
        end
        if (inst_valid && !st) begin
            check("pc_order", pc_out, exp_pc);
            check("inst_word", inst_data, mem_word(exp_pc));
            consumed++;
        end
        if (rd) exp_pc = rpc & 32'hFFFF_FFFC;
        else if (inst_valid && !st) exp_pc = exp_pc + 32'd4;
        prev_hold = inst_valid && st && !rd;
        prev_data = inst_data;
        prev_pc   = pc_out;
        tick();
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!inst_valid && n < 20) begin
            step(1'b0, 1'b0, 32'h0);
            n++;
        end
        check({tag, "_valid_timeout"}, 32'(inst_valid), 32'h1);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!imem_req && n < 20) begin
            step(1'b0, 1'b0, 32'h0);
            n++;
        end
        check({tag, "_req_timeout"}, 32'(imem_req), 32'h1);
    endtask

    task automatic drain_mem(input string tag);
        int n = 0;
        while (mem_pending && n < 20) begin
            step(1'b0, 1'b0, 32'h0);
            n++;
        end
        check({tag, "_drain_timeout"}, 32'(mem_pending), 32'h0);
    endtask

    initial begin
        logic [31:0] x;
        logic [31:0] rpc;
        logic        st;
        logic        rd;
        int          c0;

        reset       = 1'b1;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        stall       = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 32'h0;

        // Reset state
        tick();
        tick();
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_valid", 32'(inst_valid), 32'h0);
        check("rst_data", inst_data, NOP);
        check("rst_pc", pc_out, 32'h0);
        reset = 1'b0;
        tick();
        check("first_req", 32'(imem_req), 32'h1);
        check("first_addr", imem_addr, RESET_PC);

        // Zero-wait memory, no stall: a word every other cycle, in order
        repeat (12) step(1'b0, 1'b0, 32'h0);
        check("zw_count", 32'(consumed), 32'd5);

        // Stall for three cycles while the next response lands in the skid buffer
        wait_valid("s34");
        x = pc_out;
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        check("s34_hold_req", 32'(imem_req), 32'h0);
        check("s34_frozen_pc", pc_out, x);
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        check("s34_next_valid", 32'(inst_valid), 32'h1);
        check("s34_next_pc", pc_out, x + 32'd4);

        // Redirect while waiting, response arrives two cycles later and is dropped
        drain_mem("s35");
        lat_min = 3;
        lat_max = 3;
        wait_req("s35");
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0000_0102);
        check("s35_drop_req", 32'(imem_req), 32'h0);
        check("s35_flush_valid", 32'(inst_valid), 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        check("s35_req", 32'(imem_req), 32'h1);
        check("s35_addr", imem_addr, 32'h0000_0100);
        lat_min = 1;
        lat_max = 1;
        wait_valid("s35");
        check("s35_pc", pc_out, 32'h0000_0100);

        // Redirect together with a response while decode is stalled
        drain_mem("s36");
        wait_valid("s36");
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0200);
        check("s36_valid", 32'(inst_valid), 32'h0);
        check("s36_data", inst_data, NOP);
        check("s36_req", 32'(imem_req), 32'h1);
        check("s36_addr", imem_addr, 32'h0000_0200);
        wait_valid("s36b");
        check("s36_pc", pc_out, 32'h0000_0200);

        // Fetch address wraps past the top of the address space
        drain_mem("s37");
        step(1'b0, 1'b1, 32'hFFFF_FFFE);
        wait_valid("s37");
        check("s37_pc", pc_out, 32'hFFFF_FFFC);
        check("s37_req", 32'(imem_req), 32'h1);
        check("s37_wrap_addr", imem_addr, 32'h0000_0000);
        step(1'b0, 1'b0, 32'h0);
        wait_valid("s37b");
        check("s37_wrap_pc", pc_out, 32'h0000_0000);

        // Reset in WAIT, late response in the first cycle after reset is ignored
        drain_mem("s38");
        lat_min = 3;
        lat_max = 3;
        wait_req("s38");
        step(1'b0, 1'b0, 32'h0);
        reset       = 1'b1;
        stall       = 1'b0;
        redirect_en = 1'b0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        tick();
        check("s38_rst_req", 32'(imem_req), 32'h0);
        check("s38_rst_valid", 32'(inst_valid), 32'h0);
        reset       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        check("s38_late_valid", 32'(inst_valid), 32'h0);
        check("s38_late_data", inst_data, NOP);
        check("s38_req", 32'(imem_req), 32'h1);
        check("s38_addr", imem_addr, RESET_PC);
        mem_pending = 1'b0;
        exp_pc      = RESET_PC;
        prev_hold   = 1'b0;
        lat_min     = 1;
        lat_max     = 1;
        wait_valid("s38");
        check("s38_pc", pc_out, RESET_PC);
        check("s38_data", inst_data, mem_word(RESET_PC));

        // Randomized traffic: variable ready/latency, stalls and redirects
        ready_pct = 70;
        lat_min   = 1;
        lat_max   = 4;
        c0        = consumed;
        for (int i = 0; i < 1500; i++) begin
            st  = ($urandom_range(99) < 30);
            rd  = 1'b0;
            rpc = 32'h0;
            if ($urandom_range(15) == 0 && !(mem_pending && mem_cnt == 0)) begin
                rd = 1'b1;
                if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                else                        rpc = $urandom & 32'h0000_0FFF;
            end
            step(st, rd, rpc);
        end
        check("rand_progress", 32'((consumed - c0) > 50), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_zero_fetch.md
RISCV_ZERO_FETCH -- requirements
Module: riscv_zero_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, SHALL be the first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h00000013, SHALL be the value driven on inst_data whenever no valid instruction is presented.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 imem_req  output  1  SHALL flag a valid instruction-memory read request.
REQ-006 imem_addr  output  32  SHALL carry the request word address (bits [1:0] always 00).
REQ-007 imem_ready  input  1  SHALL indicate that memory accepts the request this cycle.
REQ-008 imem_rvalid  input  1  SHALL indicate that imem_rdata holds the response to the single outstanding request.
REQ-009 imem_rdata  input  32  SHALL carry the instruction word.
REQ-010 stall  input  1  SHALL indicate that decode cannot consume the presented instruction this cycle.
REQ-011 redirect_en  input  1  SHALL flag a taken jump or branch from execute.
REQ-012 redirect_pc  input  32  SHALL carry the target; bits [1:0] SHALL be ignored and forced to 00.
REQ-013 inst_valid  output  1  SHALL qualify inst_data and pc_out toward decode.
REQ-014 inst_data  output  32  SHALL carry the instruction word to decode.
REQ-015 pc_out  output  32  SHALL carry the address of inst_data.

Function
REQ-016 The block SHALL keep at most one memory request outstanding.
REQ-017 The block SHALL implement states REQ, WAIT, DROP and HOLD, with internal fetch_pc, a 32-bit skid buffer (data, pc) and registered outputs.
REQ-018 In REQ: imem_req=1 and imem_addr=fetch_pc; imem_ready=1 SHALL move to WAIT; otherwise stay in REQ. In every other state imem_req=0.
REQ-019 In WAIT, on imem_rvalid with output slot free (inst_valid=0 or stall=0): next cycle inst_data=imem_rdata, pc_out=fetch_pc, inst_valid=1; fetch_pc+=4; state SHALL go to REQ.
REQ-020 In WAIT, on imem_rvalid with inst_valid=1 and stall=1: the response SHALL be captured in the skid buffer, fetch_pc+=4, and state SHALL go to HOLD.
REQ-021 In HOLD, when stall=0 the skid contents SHALL load into the outputs the next cycle (inst_valid=1) and state SHALL go to REQ; while stall=1 it SHALL stay in HOLD.
REQ-022 When inst_valid=1 and stall=0 and no new instruction loads that cycle, inst_valid SHALL clear next cycle and inst_data SHALL become NOP_INST.
REQ-023 While stall=1, inst_valid, inst_data and pc_out SHALL hold their values.
REQ-024 Priority SHALL be reset > redirect_en > response/stall handling.
REQ-025 On redirect_en: next cycle inst_valid=0, inst_data=NOP_INST, skid discarded, fetch_pc=redirect_pc with bits [1:0] forced to 00, regardless of stall.
REQ-026 Redirect state transitions:
- REQ with imem_ready=0 -> REQ.
- REQ with imem_ready=1 -> DROP (the accepted stale request is discarded).
- WAIT without imem_rvalid -> DROP.
- WAIT with imem_rvalid -> REQ, response discarded.
- HOLD -> REQ.
- DROP -> DROP.
REQ-027 In DROP, imem_rvalid SHALL be consumed and discarded and state SHALL go to REQ; the dropped data SHALL never reach inst_data.
REQ-028 fetch_pc increments SHALL be modulo 2^32 (32'hFFFFFFFC+4 = 0).
REQ-029 imem_rvalid outside WAIT/DROP SHALL be ignored.
REQ-030 Fetch-to-decode latency SHALL be one cycle from imem_rvalid to inst_valid when the slot is free.

Reset
REQ-031 While reset=1 at a rising edge: state=REQ, fetch_pc=RESET_PC, inst_valid=0, inst_data=NOP_INST, pc_out=0, skid cleared; imem_req=0 during reset cycles.
REQ-032 Reset asserted mid-transaction (WAIT/DROP/HOLD) SHALL abandon it; a late imem_rvalid in the first cycle after reset SHALL be ignored.

Verification
REQ-033 Zero-wait memory (ready=1, rvalid one cycle after acceptance), stall=0 -> inst_valid pulses with pc_out 0,4,8,... and inst_data equal to the memory words, each exactly once.
REQ-034 stall=1 held 3 cycles while one instruction is presented and the next response arrives -> outputs frozen, HOLD entered, imem_req=0; after stall drops, pc_out advances X -> X+4 with no loss or duplicate.
REQ-035 redirect_en with redirect_pc=32'h00000102 while in WAIT, rvalid arriving 2 cycles later -> that response dropped, next imem_addr=32'h00000100, next inst_valid shows pc_out=32'h00000100.
REQ-036 redirect_en in the same cycle as imem_rvalid and stall=1 -> inst_valid=0 next cycle, skid empty, next request at the target.
REQ-037 fetch_pc=32'hFFFFFFFC fetched -> next imem_addr=32'h00000000.
REQ-038 reset pulsed during WAIT, then rvalid -> response ignored, first request at RESET_PC, inst_data=NOP_INST until the first new response.
